// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core: software CSR access, trap/mret side
// updates from pipeline control, 64-bit cycle/instret counters and interrupt-line synchronisers.
module csr_file #(
   parameter logic [31:0] HART_ID  = 32'h0000_0000,
   parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [11:0] raddr_i,
   output logic [31:0] rdata_o,
   output logic        illegal_o,
   input  logic        we_i,
   input  logic [11:0] waddr_i,
   input  logic [31:0] wdata_i,
   input  logic        instret_i,
   input  logic        irq_external_i,
   input  logic        irq_timer_i,
   input  logic        irq_software_i,
   input  logic        ie_type_i,
   input  logic        set_cause_i,
   input  logic [3:0]  trap_cause_i,
   input  logic        set_epc_i,
   input  logic [31:0] epc_i,
   input  logic        set_mtval_i,
   input  logic [31:0] mtval_i,
   input  logic        mstatus_ie_clear_i,
   input  logic        mstatus_ie_set_i,
   output logic        mstatus_ie_o,
   output logic        mie_external_o,
   output logic        mie_timer_o,
   output logic        mie_sw_o,
   output logic        mip_external_o,
   output logic        mip_timer_o,
   output logic        mip_sw_o,
   output logic [31:0] mtvec_o,
   output logic [31:0] epc_o
);

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   logic        mstatus_mie_q;
   logic        mstatus_mpie_q;
   logic        mie_meie_q;
   logic        mie_mtie_q;
   logic        mie_msie_q;
   logic [31:0] mtvec_q;
   logic [31:0] mscratch_q;
   logic [31:2] mepc_q;
   logic [31:0] mcause_q;
   logic [31:0] mtval_q;
   logic [63:0] mcycle_q;
   logic [63:0] mcycle_d;
   logic [63:0] minstret_q;
   logic [63:0] minstret_d;
   // Index 2/1/0 = external/timer/software throughout.
   logic [2:0]  irq_meta_q;
   logic [2:0]  irq_sync_q;

   logic wr_mstatus;
   logic wr_mie;
   logic wr_mtvec;
   logic wr_mscratch;
   logic wr_mepc;
   logic wr_mcause;
   logic wr_mtval;
   logic wr_mcycle;
   logic wr_mcycleh;
   logic wr_minstret;
   logic wr_minstreth;

   // The two address bits dropped by mepc alignment are intentionally discarded.
   logic unused_epc_lsbs;
   assign unused_epc_lsbs = ^epc_i[1:0];

   assign wr_mstatus   = we_i && (waddr_i == CSR_MSTATUS);
   assign wr_mie       = we_i && (waddr_i == CSR_MIE);
   assign wr_mtvec     = we_i && (waddr_i == CSR_MTVEC);
   assign wr_mscratch  = we_i && (waddr_i == CSR_MSCRATCH);
   assign wr_mepc      = we_i && (waddr_i == CSR_MEPC);
   assign wr_mcause    = we_i && (waddr_i == CSR_MCAUSE);
   assign wr_mtval     = we_i && (waddr_i == CSR_MTVAL);
   assign wr_mcycle    = we_i && (waddr_i == CSR_MCYCLE);
   assign wr_mcycleh   = we_i && (waddr_i == CSR_MCYCLEH);
   assign wr_minstret  = we_i && (waddr_i == CSR_MINSTRET);
   assign wr_minstreth = we_i && (waddr_i == CSR_MINSTRETH);

   // Trap-side updates take priority over a software write to the same register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
      end else if (mstatus_ie_clear_i) begin
         mstatus_mpie_q <= mstatus_mie_q;
         mstatus_mie_q  <= 1'b0;
      end else if (mstatus_ie_set_i) begin
         mstatus_mie_q  <= mstatus_mpie_q;
         mstatus_mpie_q <= 1'b1;
      end else if (wr_mstatus) begin
         mstatus_mie_q  <= wdata_i[3];
         mstatus_mpie_q <= wdata_i[7];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mie_meie_q <= 1'b0;
         mie_mtie_q <= 1'b0;
         mie_msie_q <= 1'b0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
      end else begin
         if (wr_mie) begin
            mie_meie_q <= wdata_i[11];
            mie_mtie_q <= wdata_i[7];
            mie_msie_q <= wdata_i[3];
         end
         if (wr_mtvec) begin
            mtvec_q <= wdata_i;
         end
         if (wr_mscratch) begin
            mscratch_q <= wdata_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mepc_q   <= '0;
         mcause_q <= '0;
         mtval_q  <= '0;
      end else begin
         if (set_epc_i) begin
            mepc_q <= epc_i[31:2];
         end else if (wr_mepc) begin
            mepc_q <= wdata_i[31:2];
         end
         if (set_cause_i) begin
            mcause_q <= {ie_type_i, 27'b0, trap_cause_i};
            mtval_q  <= set_mtval_i ? mtval_i : 32'h0;
         end else begin
            if (wr_mcause) begin
               mcause_q <= wdata_i;
            end
            if (wr_mtval) begin
               mtval_q <= wdata_i;
            end
         end
      end
   end

   // A software write to either half freezes the whole counter for that cycle.
   always_comb begin
      mcycle_d = mcycle_q + 64'd1;
      if (wr_mcycle || wr_mcycleh) begin
         mcycle_d = mcycle_q;
         if (wr_mcycle) begin
            mcycle_d[31:0] = wdata_i;
         end
         if (wr_mcycleh) begin
            mcycle_d[63:32] = wdata_i;
         end
      end
      minstret_d = minstret_q + {63'd0, instret_i};
      if (wr_minstret || wr_minstreth) begin
         minstret_d = minstret_q;
         if (wr_minstret) begin
            minstret_d[31:0] = wdata_i;
         end
         if (wr_minstreth) begin
            minstret_d[63:32] = wdata_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
         irq_meta_q <= '0;
         irq_sync_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
         irq_meta_q <= {irq_external_i, irq_timer_i, irq_software_i};
         irq_sync_q <= irq_meta_q;
      end
   end

   always_comb begin
      rdata_o   = '0;
      illegal_o = 1'b0;
      case (raddr_i)
         CSR_MSTATUS:   rdata_o = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
         CSR_MISA:      rdata_o = MISA_VAL;
         CSR_MIE:       rdata_o = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 3'b0, mie_msie_q, 3'b0};
         CSR_MTVEC:     rdata_o = mtvec_q;
         CSR_MSCRATCH:  rdata_o = mscratch_q;
         CSR_MEPC:      rdata_o = {mepc_q, 2'b00};
         CSR_MCAUSE:    rdata_o = mcause_q;
         CSR_MTVAL:     rdata_o = mtval_q;
         CSR_MIP:       rdata_o = {20'b0, irq_sync_q[2], 3'b0, irq_sync_q[1], 3'b0, irq_sync_q[0], 3'b0};
         CSR_MCYCLE,
         CSR_CYCLE:     rdata_o = mcycle_q[31:0];
         CSR_MCYCLEH,
         CSR_CYCLEH:    rdata_o = mcycle_q[63:32];
         CSR_MINSTRET,
         CSR_INSTRET:   rdata_o = minstret_q[31:0];
         CSR_MINSTRETH,
         CSR_INSTRETH:  rdata_o = minstret_q[63:32];
         CSR_MVENDORID,
         CSR_MARCHID,
         CSR_MIMPID:    rdata_o = '0;
         CSR_MHARTID:   rdata_o = HART_ID;
         default:       illegal_o = 1'b1;
      endcase
   end

   assign mstatus_ie_o   = mstatus_mie_q;
   assign mie_external_o = mie_meie_q;
   assign mie_timer_o    = mie_mtie_q;
   assign mie_sw_o       = mie_msie_q;
   assign mip_external_o = irq_sync_q[2];
   assign mip_timer_o    = irq_sync_q[1];
   assign mip_sw_o       = irq_sync_q[0];
   assign mtvec_o        = mtvec_q;
   assign epc_o          = {mepc_q, 2'b00};

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset/read/write tables plus hand-written
// trap, conflict, counter and interrupt-synchroniser sequences.
module tb_csr_file;

   logic        clk_i;
   logic        rst_i;
   logic [11:0] raddr_i;
   logic [31:0] rdata_o;
   logic        illegal_o;
   logic        we_i;
   logic [11:0] waddr_i;
   logic [31:0] wdata_i;
   logic        instret_i;
   logic        irq_external_i;
   logic        irq_timer_i;
   logic        irq_software_i;
   logic        ie_type_i;
   logic        set_cause_i;
   logic [3:0]  trap_cause_i;
   logic        set_epc_i;
   logic [31:0] epc_i;
   logic        set_mtval_i;
   logic [31:0] mtval_i;
   logic        mstatus_ie_clear_i;
   logic        mstatus_ie_set_i;
   logic        mstatus_ie_o;
   logic        mie_external_o;
   logic        mie_timer_o;
   logic        mie_sw_o;
   logic        mip_external_o;
   logic        mip_timer_o;
   logic        mip_sw_o;
   logic [31:0] mtvec_o;
   logic [31:0] epc_o;

   csr_file dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .raddr_i            (raddr_i),
      .rdata_o            (rdata_o),
      .illegal_o          (illegal_o),
      .we_i               (we_i),
      .waddr_i            (waddr_i),
      .wdata_i            (wdata_i),
      .instret_i          (instret_i),
      .irq_external_i     (irq_external_i),
      .irq_timer_i        (irq_timer_i),
      .irq_software_i     (irq_software_i),
      .ie_type_i          (ie_type_i),
      .set_cause_i        (set_cause_i),
      .trap_cause_i       (trap_cause_i),
      .set_epc_i          (set_epc_i),
      .epc_i              (epc_i),
      .set_mtval_i        (set_mtval_i),
      .mtval_i            (mtval_i),
      .mstatus_ie_clear_i (mstatus_ie_clear_i),
      .mstatus_ie_set_i   (mstatus_ie_set_i),
      .mstatus_ie_o       (mstatus_ie_o),
      .mie_external_o     (mie_external_o),
      .mie_timer_o        (mie_timer_o),
      .mie_sw_o           (mie_sw_o),
      .mip_external_o     (mip_external_o),
      .mip_timer_o        (mip_timer_o),
      .mip_sw_o           (mip_sw_o),
      .mtvec_o            (mtvec_o),
      .epc_o              (epc_o)
   );

   // Clock: long period so several combinational reads fit inside one cycle.
   initial clk_i = 1'b0;
   always #50 clk_i = ~clk_i;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] exp_data;
      logic        exp_ill;
   } rd_vec_t;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_ill;
   } wr_vec_t;

   rd_vec_t     rst_tab[16];
   wr_vec_t     wr_tab[11];
   logic [32:0] exp_q[$];
   int          checks;
   int          failures;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      logic [32:0] e;
      exp_q.push_back(exp);
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, e);
      end
   endtask

   task automatic expect_csr(input string name, input logic [11:0] a,
                             input logic [31:0] exp, input logic exp_ill);
      raddr_i = a;
      #1;
      check(name, {illegal_o, rdata_o}, {exp_ill, exp});
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      we_i    = 1'b1;
      waddr_i = a;
      wdata_i = d;
      tick();
      we_i    = 1'b0;
   endtask

   task automatic clear_trap_inputs();
      mstatus_ie_clear_i = 1'b0;
      mstatus_ie_set_i   = 1'b0;
      set_cause_i        = 1'b0;
      set_epc_i          = 1'b0;
      set_mtval_i        = 1'b0;
      ie_type_i          = 1'b0;
      trap_cause_i       = 4'h0;
      epc_i              = 32'h0;
      mtval_i            = 32'h0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_i = 1'b1;
      raddr_i = 12'h0;
      we_i = 1'b0;
      waddr_i = 12'h0;
      wdata_i = 32'h0;
      instret_i = 1'b0;
      irq_external_i = 1'b0;
      irq_timer_i = 1'b0;
      irq_software_i = 1'b0;
      clear_trap_inputs();

      rst_tab[0]  = '{12'h300, 32'h0000_1800, 1'b0};
      rst_tab[1]  = '{12'h304, 32'h0, 1'b0};
      rst_tab[2]  = '{12'h305, 32'h0, 1'b0};
      rst_tab[3]  = '{12'h340, 32'h0, 1'b0};
      rst_tab[4]  = '{12'h341, 32'h0, 1'b0};
      rst_tab[5]  = '{12'h342, 32'h0, 1'b0};
      rst_tab[6]  = '{12'h343, 32'h0, 1'b0};
      rst_tab[7]  = '{12'h344, 32'h0, 1'b0};
      rst_tab[8]  = '{12'hB00, 32'h0, 1'b0};
      rst_tab[9]  = '{12'hB80, 32'h0, 1'b0};
      rst_tab[10] = '{12'hC02, 32'h0, 1'b0};
      rst_tab[11] = '{12'hF11, 32'h0, 1'b0};
      rst_tab[12] = '{12'hF14, 32'h0, 1'b0};
      rst_tab[13] = '{12'h301, 32'h4000_0100, 1'b0};
      rst_tab[14] = '{12'h7C0, 32'h0, 1'b1};
      rst_tab[15] = '{12'h000, 32'h0, 1'b1};

      wr_tab[0]  = '{12'h305, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      wr_tab[1]  = '{12'h340, 32'h1234_5678, 32'h1234_5678, 1'b0};
      wr_tab[2]  = '{12'h341, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0};
      wr_tab[3]  = '{12'h342, 32'h8000_0007, 32'h8000_0007, 1'b0};
      wr_tab[4]  = '{12'h343, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
      wr_tab[5]  = '{12'h304, 32'hFFFF_FFFF, 32'h0000_0888, 1'b0};
      wr_tab[6]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 1'b0};
      wr_tab[7]  = '{12'h344, 32'hFFFF_FFFF, 32'h0, 1'b0};
      wr_tab[8]  = '{12'h301, 32'h0, 32'h4000_0100, 1'b0};
      wr_tab[9]  = '{12'hF14, 32'h5, 32'h0, 1'b0};
      wr_tab[10] = '{12'h7C0, 32'hFFFF_FFFF, 32'h0, 1'b1};

      // Reset: one edge high, then read everything before the next edge.
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         expect_csr($sformatf("reset_rd_%h", rst_tab[i].addr), rst_tab[i].addr,
                    rst_tab[i].exp_data, rst_tab[i].exp_ill);
      end
      check("reset_flag_outputs",
            {26'b0, mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o,
             mip_external_o, mip_timer_o, mip_sw_o}, 33'h0);
      check("reset_mtvec_epc", {1'b0, mtvec_o | epc_o}, 33'h0);
      tick();
      expect_csr("mcycle_first_cycle", 12'hB00, 32'h1, 1'b0);

      for (int i = 0; i < 11; i++) begin
         csr_write(wr_tab[i].addr, wr_tab[i].wdata);
         expect_csr($sformatf("wr_rd_%h", wr_tab[i].addr), wr_tab[i].addr,
                    wr_tab[i].exp_data, wr_tab[i].exp_ill);
      end
      check("mtvec_out", {1'b0, mtvec_o}, {1'b0, 32'hDEAD_BEEF});

      // Trap entry then mret.
      csr_write(12'h300, 32'h8);
      check("mstatus_ie_set_by_sw", {32'b0, mstatus_ie_o}, 33'h1);
      expect_csr("mstatus_after_sw", 12'h300, 32'h0000_1808, 1'b0);
      mstatus_ie_clear_i = 1'b1;
      set_cause_i = 1'b1; ie_type_i = 1'b1; trap_cause_i = 4'hB;
      set_epc_i = 1'b1; epc_i = 32'h8000_0107;
      set_mtval_i = 1'b1; mtval_i = 32'h1234;
      tick();
      clear_trap_inputs();
      expect_csr("trap_mstatus", 12'h300, 32'h0000_1880, 1'b0);
      expect_csr("trap_mcause", 12'h342, 32'h8000_000B, 1'b0);
      expect_csr("trap_mepc", 12'h341, 32'h8000_0104, 1'b0);
      expect_csr("trap_mtval", 12'h343, 32'h0000_1234, 1'b0);
      check("trap_ie_out", {32'b0, mstatus_ie_o}, 33'h0);
      check("trap_epc_out", {1'b0, epc_o}, {1'b0, 32'h8000_0104});
      mstatus_ie_set_i = 1'b1;
      tick();
      clear_trap_inputs();
      expect_csr("mret_mstatus", 12'h300, 32'h0000_1888, 1'b0);
      check("mret_ie_out", {32'b0, mstatus_ie_o}, 33'h1);
      mstatus_ie_clear_i = 1'b1;
      mstatus_ie_set_i = 1'b1;
      tick();
      clear_trap_inputs();
      expect_csr("clear_wins_mstatus", 12'h300, 32'h0000_1880, 1'b0);

      // Trap-side vs software conflicts.
      we_i = 1'b1; waddr_i = 12'h341; wdata_i = 32'h10;
      set_epc_i = 1'b1; epc_i = 32'h20;
      set_cause_i = 1'b1; trap_cause_i = 4'h3; mtval_i = 32'hFFFF;
      tick();
      we_i = 1'b0;
      clear_trap_inputs();
      expect_csr("conflict_mepc", 12'h341, 32'h20, 1'b0);
      expect_csr("cause_no_mtval", 12'h343, 32'h0, 1'b0);
      expect_csr("cause_sync_irq0", 12'h342, 32'h3, 1'b0);
      we_i = 1'b1; waddr_i = 12'h340; wdata_i = 32'h55;
      set_epc_i = 1'b1; epc_i = 32'h40;
      tick();
      we_i = 1'b0;
      clear_trap_inputs();
      expect_csr("other_sw_commits", 12'h340, 32'h55, 1'b0);
      expect_csr("other_trap_mepc", 12'h341, 32'h40, 1'b0);
      we_i = 1'b1; waddr_i = 12'h342; wdata_i = 32'h77;
      set_cause_i = 1'b1; ie_type_i = 1'b1; trap_cause_i = 4'h7;
      tick();
      we_i = 1'b0;
      clear_trap_inputs();
      expect_csr("conflict_mcause", 12'h342, 32'h8000_0007, 1'b0);
      set_mtval_i = 1'b1; mtval_i = 32'h99;
      tick();
      clear_trap_inputs();
      expect_csr("mtval_without_cause", 12'h343, 32'h0, 1'b0);

      // Counters.
      csr_write(12'hB00, 32'hFFFF_FFFF);
      csr_write(12'hB80, 32'h0);
      expect_csr("mcycle_wr_lo", 12'hB00, 32'hFFFF_FFFF, 1'b0);
      expect_csr("mcycle_wr_hi", 12'hB80, 32'h0, 1'b0);
      tick();
      expect_csr("mcycle_carry_hi", 12'hB80, 32'h1, 1'b0);
      expect_csr("mcycle_carry_lo", 12'hB00, 32'h0, 1'b0);
      expect_csr("cycleh_alias", 12'hC80, 32'h1, 1'b0);
      csr_write(12'hC00, 32'h1234_5678);
      expect_csr("cycle_ro", 12'hC00, 32'h1, 1'b0);
      csr_write(12'hB00, 32'hFFFF_FFFF);
      csr_write(12'hB80, 32'hFFFF_FFFF);
      tick();
      expect_csr("mcycle_wrap_lo", 12'hB00, 32'h0, 1'b0);
      expect_csr("mcycle_wrap_hi", 12'hB80, 32'h0, 1'b0);
      instret_i = 1'b1;
      tick(); tick(); tick();
      instret_i = 1'b0;
      expect_csr("instret_3", 12'hC02, 32'h3, 1'b0);
      tick();
      expect_csr("instret_hold", 12'hB02, 32'h3, 1'b0);
      instret_i = 1'b1;
      csr_write(12'hB02, 32'h100);
      instret_i = 1'b0;
      expect_csr("instret_wr_suppress", 12'hB02, 32'h100, 1'b0);
      csr_write(12'hB02, 32'hFFFF_FFFF);
      csr_write(12'hB82, 32'hFFFF_FFFF);
      instret_i = 1'b1;
      tick();
      instret_i = 1'b0;
      expect_csr("instret_wrap_lo", 12'hB02, 32'h0, 1'b0);
      expect_csr("instret_wrap_hi", 12'hC82, 32'h0, 1'b0);

      // Interrupt synchroniser latency and mie bits.
      irq_timer_i = 1'b1;
      tick();
      check("mip_timer_edge1", {32'b0, mip_timer_o}, 33'h0);
      tick();
      check("mip_timer_edge2", {32'b0, mip_timer_o}, 33'h1);
      expect_csr("mip_read", 12'h344, 32'h80, 1'b0);
      csr_write(12'h304, 32'h880);
      check("mie_bits", {30'b0, mie_external_o, mie_timer_o, mie_sw_o}, 33'h6);

      // Reset landing in the middle of a trap.
      rst_i = 1'b1;
      mstatus_ie_clear_i = 1'b1;
      set_cause_i = 1'b1; trap_cause_i = 4'h5;
      set_epc_i = 1'b1; epc_i = 32'h100;
      tick();
      rst_i = 1'b0;
      clear_trap_inputs();
      expect_csr("midtrap_rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);
      expect_csr("midtrap_rst_mcause", 12'h342, 32'h0, 1'b0);
      expect_csr("midtrap_rst_mepc", 12'h341, 32'h0, 1'b0);
      check("midtrap_rst_flags",
            {26'b0, mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o,
             mip_external_o, mip_timer_o, mip_sw_o}, 33'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
